pipe_hazard_ctrl: RTL

//  Pipeline sequencer for the 5-stage F/D/E/M/W core. Takes register-dependency info,

---
 rtl/pipe_pkg.sv | 17 +
 rtl/md_busy_fsm.sv | 72 +++++++
 rtl/pipe_hazard_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings for the F/D/E/M/W pipeline sequencer: Tuse/Tnew codes,
// HI/LO busy-FSM states and default redirect/latency constants.
package pipe_pkg;

  localparam logic [1:0]  TUSE_NONE           = 2'd3;
  localparam logic [1:0]  TNEW_READY          = 2'd0;
  localparam logic [31:0] EXC_VECTOR_DEFAULT  = 32'h0000_4180;
  localparam int unsigned MULT_CYCLES_DEFAULT = 32'd5;
  localparam int unsigned DIV_CYCLES_DEFAULT  = 32'd10;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MULT = 2'd1,
    MD_DIV  = 2'd2
  } mdState_e;

endpackage

// File: rtl/md_busy_fsm.sv
// Busy tracker for the multi-cycle HI/LO unit: a load-and-count-down FSM
// whose busy flag rises the cycle after a mult/div leaves E.
module md_busy_fsm
  import pipe_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic e_md_start,
  input  logic e_md_is_div,
  input  logic m_exc_req,
  output logic md_busy
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 32'd1);

  mdState_e         state_r, stateNext_s;
  logic [CNT_W-1:0] cnt_r, cntNext_s;

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= MD_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= stateNext_s;
      cnt_r   <= cntNext_s;
    end
  end

  // Next-state logic; a start flushed by an M-stage exception never launches.
  always_comb begin
    stateNext_s = state_r;
    cntNext_s   = cnt_r;
    case (state_r)
      MD_IDLE: begin
        if (e_md_start && !m_exc_req) begin
          if (e_md_is_div) begin
            stateNext_s = MD_DIV;
            cntNext_s   = CNT_W'(DIV_CYCLES);
          end else begin
            stateNext_s = MD_MULT;
            cntNext_s   = CNT_W'(MULT_CYCLES);
          end
        end else begin
          stateNext_s = MD_IDLE;
        end
      end
      MD_MULT, MD_DIV: begin
        if (cnt_r <= CNT_W'(1)) begin
          stateNext_s = MD_IDLE;
          cntNext_s   = '0;
        end else begin
          cntNext_s   = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        stateNext_s = MD_IDLE;
        cntNext_s   = '0;
      end
    endcase
  end

  // Busy output decode.
  always_comb begin
    md_busy = (state_r != MD_IDLE);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/flush/redirect sequencer for the 5-stage core. Optional stall
// performance counter output stall_cnt is built when STALL_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEFAULT,
  parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [1:0]  d_tuse_rs,
  input  logic [1:0]  d_tuse_rt,
  input  logic        d_is_md,
  input  logic        d_is_eret,
  input  logic [4:0]  e_dst,
  input  logic [4:0]  m_dst,
  input  logic        e_we,
  input  logic        m_we,
  input  logic [1:0]  e_tnew,
  input  logic [1:0]  m_tnew,
  input  logic        e_md_start,
  input  logic        e_md_is_div,
  input  logic        m_exc_req,
  input  logic [31:0] epc,
  output logic        fd_en,
  output logic        d_flush,
  output logic        e_flush,
  output logic        m_flush,
  output logic        w_flush,
  output logic        redirect_en,
  output logic [31:0] redirect_pc,
  output logic        md_busy
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  logic rsStall_s, rtStall_s, dataStall_s, mdStall_s, stall_s;

  md_busy_fsm #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) uMdBusy (
    .clk         (clk),
    .reset       (reset),
    .e_md_start  (e_md_start),
    .e_md_is_div (e_md_is_div),
    .m_exc_req   (m_exc_req),
    .md_busy     (md_busy)
  );

  // Register-dependency and HI/LO stall detection; $0 and unused sources never stall.
  always_comb begin
    rsStall_s = (d_rs != 5'd0) && (d_tuse_rs != TUSE_NONE) &&
                ((e_we && (e_dst == d_rs) && (d_tuse_rs < e_tnew)) ||
                 (m_we && (m_dst == d_rs) && (d_tuse_rs < m_tnew)));
    rtStall_s = (d_rt != 5'd0) && (d_tuse_rt != TUSE_NONE) &&
                ((e_we && (e_dst == d_rt) && (d_tuse_rt < e_tnew)) ||
                 (m_we && (m_dst == d_rt) && (d_tuse_rt < m_tnew)));
    dataStall_s = rsStall_s | rtStall_s;
    mdStall_s   = d_is_md && (md_busy || e_md_start);
    stall_s     = dataStall_s | mdStall_s;
  end

  // Pipeline control: exception beats stall, stall beats eret; reset forces idle values.
  always_comb begin
    fd_en       = 1'b1;
    d_flush     = 1'b0;
    e_flush     = 1'b0;
    m_flush     = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 32'h0000_0000;
    if (!reset) begin
      fd_en = 1'b1;
    end else if (m_exc_req) begin
      d_flush     = 1'b1;
      e_flush     = 1'b1;
      m_flush     = 1'b1;
      redirect_en = 1'b1;
      redirect_pc = EXC_VECTOR;
    end else if (stall_s) begin
      fd_en   = 1'b0;
      e_flush = 1'b1;
    end else if (d_is_eret) begin
      d_flush     = 1'b1;
      redirect_en = 1'b1;
      redirect_pc = epc;
    end else begin
      fd_en = 1'b1;
    end
  end

  // The W-stage instruction always retires, even on an exception.
  assign w_flush = 1'b0;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] stallCnt_r;

  // Free-running count of stall cycles, wrapping at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCnt_r <= 32'd0;
    end else if (stall_s) begin
      stallCnt_r <= stallCnt_r + 32'd1;
    end else begin
      stallCnt_r <= stallCnt_r;
    end
  end

  assign stall_cnt = stallCnt_r;
`endif

endmodule
